ysyx_mem_arbiter: RTL and testbench
===================================

# ysyx_mem_arbiter

Two-requester arbiter and sequencer for the single shared DPI memory port. It serialises instruction fetch (IFU) and load/store (LSU) traffic onto one valid/ready request channel with a response channel. It keeps exactly one transaction outstanding and returns each response to the requester that issued it.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MASK_W, 8, write byte-mask width; matches the `byte` mask of `pmem_write`

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; synchronous, active-low
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  IFU response; one-cycle pulse
- ifu_rdata  out  DATA_W  fetched word
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  load/store address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  MASK_W  store byte mask
- lsu_resp_valid  out  1  LSU response; one-cycle pulse; store acknowledge or load data
- lsu_rdata  out  DATA_W  load data
- mem_req_valid  out  1  request to the memory port
- mem_req_ready  in  1  memory port accepts the request
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_W/1/DATA_W/MASK_W  latched request fields
- mem_resp_valid  in  1  memory response
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, REQ, WAIT.
- **IDLE**
  - Arbitrate between the two valid requests and assert ready to the winner only (combinational).
  - On accept, latch addr/wen/wdata/wmask and owner, then go to REQ.
  - IFU fields latch as wen=0, wdata=0, wmask=0.
- **REQ**
  - mem_req_valid=1 and the latched fields drive mem_*.
  - On mem_req_ready, go to WAIT. Otherwise hold; the fields must stay stable.
- **WAIT**
  - mem_req_valid=0.
  - When mem_resp_valid=1: the owner's resp_valid equals mem_resp_valid combinationally, rdata passes mem_rdata through, and the FSM goes to IDLE.
  - Stores also wait for mem_resp_valid as their acknowledge.
- Non-owner resp_valid stays 0. Both rdata outputs always show mem_rdata.
- mem_resp_valid in IDLE or REQ is ignored; no output changes.
- Requester signals in REQ/WAIT are ignored, and both ready outputs are 0.
- Default arbitration is fixed priority: LSU beats IFU.

## Timing
- Reset values, and all outputs while rst_n=0: state=IDLE, both ready=0, both resp_valid=0, mem_req_valid=0, busy=0, latched fields=0, last_grant=LSU.
- Cycle N: request accepted. Cycle N+1: mem_req_valid=1. If mem_req_ready=1 at N+1, WAIT at N+2.
- Earliest response is at N+2, so accept-to-response latency is 2 cycles minimum.
- The next accept can happen at N+3, giving a 3-cycle minimum spacing.
- Reset asserted in REQ/WAIT: the outstanding transaction is dropped with no response to the owner. The next cycle is IDLE with all outputs 0.
- A requester may drop valid before accept without side effects.

## Configuration
- YSYX_ARB_RR_EN defined:
  - Round-robin arbitration. When both requesters are valid, the one that did not win last gets the grant.
  - last_grant updates on every accept and resets to LSU, so the first tie goes to IFU.
  - A single valid requester always wins.
- YSYX_ARB_RR_EN undefined: fixed LSU priority, and last_grant is not implemented.

## Structure
- Package ysyx_mem_pkg holds:
  - state enum {IDLE, REQ, WAIT}
  - owner encoding OWN_IFU=0, OWN_LSU=1
  - default ADDR_W/DATA_W/MASK_W constants
- Sub-module ysyx_rr_pick: 2-way picker taking the two valids plus last_grant and producing a one-hot grant. The fixed-priority mode is the same module with last_grant tied to IFU.

## Test plan
- **Lone IFU fetch:** ifu_addr=0x80000000, mem_req_ready=1 at N+1, mem_resp_valid with mem_rdata=0x00000413 at N+2 → ifu_req_ready at N, mem_addr=0x80000000 and mem_wen=0 at N+1, ifu_resp_valid=1 and ifu_rdata=0x00000413 at N+2, lsu_resp_valid=0.
- **Both valid, fixed priority:** LSU store to 0x80001000 with wdata=0xDEADBEEF and wmask=0x0F → LSU granted first with mem_wmask=0x0F; IFU granted at the next IDLE.
- **Both valid with YSYX_ARB_RR_EN, repeated 4×:** grants alternate IFU, LSU, IFU, LSU starting after reset.
- **Backpressure:** mem_req_ready low for 3 cycles → mem_req_valid stays high and mem_addr/mem_wdata/mem_wmask stay constant; WAIT entered the cycle after ready goes high.
- **Spurious response:** mem_resp_valid pulsed in IDLE and in REQ → no resp_valid on either requester and no state change.
- **Reset in WAIT:** rst_n=0 for 1 cycle while WAIT holds an LSU load → next cycle busy=0 and all outputs 0; a later mem_resp_valid produces no lsu_resp_valid.

Source files
------------

// File: rtl/ysyx_mem_arbiter_pkg.sv
// Shared types and default widths for the IFU/LSU memory arbiter.
// Optional round-robin arbitration is enabled by YSYX_ARB_RR_EN.
package ysyx_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int MASK_W_DEF = 8;

endpackage

// File: rtl/ysyx_mem_arbiter_if.sv
// Requester and memory-port bundle of the arbiter; the arbiter takes the
// slave modport, the environment (cores / memory model) the master modport.
interface ysyx_mem_arbiter_if
    import ysyx_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int MASK_W = MASK_W_DEF
) ();

    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_rdata;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic              lsu_wen;
    logic [DATA_W-1:0] lsu_wdata;
    logic [MASK_W-1:0] lsu_wmask;
    logic              lsu_resp_valid;
    logic [DATA_W-1:0] lsu_rdata;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );

endinterface

// File: rtl/ysyx_mem_arbiter_rr_pick.sv
// Two-way picker: one-hot grant (bit 0 = IFU, bit 1 = LSU). A tie goes to the
// requester that did not win last; tying last_grant_i to IFU gives LSU priority.
module ysyx_rr_pick
    import ysyx_mem_pkg::*;
(
    input  logic       ifu_valid_i,
    input  logic       lsu_valid_i,
    input  owner_e     last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        // NOTE: default every always_comb output first so no path infers a latch.
        grant_o = 2'b00;
        if (ifu_valid_i && lsu_valid_i) begin
            if (last_grant_i == OWN_IFU) grant_o[1] = 1'b1;
            else                         grant_o[0] = 1'b1;
        end else begin
            grant_o[0] = ifu_valid_i;
            grant_o[1] = lsu_valid_i;
        end
    end

endmodule

// File: rtl/ysyx_mem_arbiter.sv
// Serialises IFU and LSU requests onto one memory port, one transaction in
// flight. Define YSYX_ARB_RR_EN for round-robin instead of LSU priority.
module ysyx_mem_arbiter
    import ysyx_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int MASK_W = MASK_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    ysyx_mem_arbiter_if.slave   bus,
    output logic                busy
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;

    logic [1:0] grant;
    owner_e     pick_last;
    logic       ifu_ready, lsu_ready, ifu_resp, lsu_resp, req_valid;

    ysyx_rr_pick u_pick (
        .ifu_valid_i  (bus.ifu_req_valid),
        .lsu_valid_i  (bus.lsu_req_valid),
        .last_grant_i (pick_last),
        .grant_o      (grant)
    );

`ifdef YSYX_ARB_RR_EN
    owner_e last_grant_q;

    always_ff @(posedge clk) begin
        if (!rst_n)                      last_grant_q <= OWN_LSU;
        else if (ifu_ready || lsu_ready) last_grant_q <= owner_d;
    end

    assign pick_last = last_grant_q;
`else
    assign pick_last = OWN_IFU;
`endif

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWN_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        ifu_ready = 1'b0;
        lsu_ready = 1'b0;
        ifu_resp  = 1'b0;
        lsu_resp  = 1'b0;
        req_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant[1]) begin
                    lsu_ready = 1'b1;
                    owner_d   = OWN_LSU;
                    addr_d    = bus.lsu_addr;
                    wen_d     = bus.lsu_wen;
                    wdata_d   = bus.lsu_wdata;
                    wmask_d   = bus.lsu_wmask;
                    state_d   = REQ;
                end else if (grant[0]) begin
                    ifu_ready = 1'b1;
                    owner_d   = OWN_IFU;
                    addr_d    = bus.ifu_addr;
                    wen_d     = 1'b0;
                    wdata_d   = '0;
                    wmask_d   = '0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                req_valid = 1'b1;
                if (bus.mem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (bus.mem_resp_valid) begin
                    if (owner_q == OWN_IFU) ifu_resp = 1'b1;
                    else                    lsu_resp = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset is synchronous, so outputs must be forced quiet while it is held.
        if (!rst_n) begin
            ifu_ready = 1'b0;
            lsu_ready = 1'b0;
            ifu_resp  = 1'b0;
            lsu_resp  = 1'b0;
            req_valid = 1'b0;
        end
    end

    assign bus.ifu_req_ready  = ifu_ready;
    assign bus.lsu_req_ready  = lsu_ready;
    assign bus.ifu_resp_valid = ifu_resp;
    assign bus.lsu_resp_valid = lsu_resp;
    assign bus.ifu_rdata      = bus.mem_rdata;
    assign bus.lsu_rdata      = bus.mem_rdata;

    assign bus.mem_req_valid  = req_valid;
    assign bus.mem_addr       = rst_n ? addr_q  : '0;
    assign bus.mem_wen        = rst_n ? wen_q   : 1'b0;
    assign bus.mem_wdata      = rst_n ? wdata_q : '0;
    assign bus.mem_wmask      = rst_n ? wmask_q : '0;

    assign busy = rst_n && (state_q != IDLE);

endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// Directed bench for ysyx_mem_arbiter: a scoreboard queue of expected
// responses, popped by a monitor whenever either requester sees resp_valid.
module tb_ysyx_mem_arbiter;
    import ysyx_mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    ysyx_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .MASK_W(8)) bus ();

    ysyx_mem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    typedef struct {
        owner_e      own;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every response must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (bus.ifu_resp_valid || bus.lsu_resp_valid)) begin
            if (sb.size() == 0) begin
                check("resp_unexpected", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 2'b00);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_ifu_valid", bus.ifu_resp_valid, e.own == OWN_IFU);
                check("resp_lsu_valid", bus.lsu_resp_valid, e.own == OWN_LSU);
                check("resp_rdata", (e.own == OWN_IFU) ? bus.ifu_rdata : bus.lsu_rdata, e.rdata);
            end
        end
    end

    // Called in the first REQ cycle: holds mem_req_ready low for 'stall' cycles,
    // checks the request fields every REQ cycle, then answers in WAIT with rd.
    task automatic serve(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [7:0] m, input int stall, input logic [31:0] rd);
        for (int i = 0; i <= stall; i++) begin
            bus.mem_req_ready = (i == stall);
            #1;
            check("req_valid", bus.mem_req_valid, 1'b1);
            check("req_addr", bus.mem_addr, a);
            check("req_wen", bus.mem_wen, w);
            check("req_wdata", bus.mem_wdata, d);
            check("req_wmask", bus.mem_wmask, m);
            check("req_readys", {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b00);
            tick();
        end
        bus.mem_req_ready = 1'b0;
        #1;
        check("wait_req_valid", bus.mem_req_valid, 1'b0);
        check("wait_busy", busy, 1'b1);
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = rd;
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
        #1;
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

`ifdef YSYX_ARB_RR_EN
    owner_e tie_win[4] = '{OWN_IFU, OWN_LSU, OWN_IFU, OWN_LSU};
`else
    owner_e tie_win[4] = '{OWN_LSU, OWN_LSU, OWN_LSU, OWN_LSU};
`endif

    initial begin
        bus.ifu_req_valid  = 1'b0;
        bus.ifu_addr       = '0;
        bus.lsu_req_valid  = 1'b0;
        bus.lsu_addr       = '0;
        bus.lsu_wen        = 1'b0;
        bus.lsu_wdata      = '0;
        bus.lsu_wmask      = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;

        // Reset: a valid request during reset must not be accepted.
        bus.ifu_req_valid = 1'b1;
        tick();
        tick();
        check("rst_readys", {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
        check("rst_mem_fields", {bus.mem_addr, bus.mem_wen, bus.mem_wmask}, '0);
        bus.ifu_req_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Lone IFU fetch.
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0000;
        sb.push_back('{OWN_IFU, 32'h0000_0413});
        #1;
        check("ifu_lone_ready", {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b10);
        tick();
        bus.ifu_req_valid = 1'b0;
        serve(32'h8000_0000, 1'b0, 32'h0, 8'h00, 0, 32'h0000_0413);

        // Both valid: LSU store wins, IFU follows at the next IDLE.
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 32'h8000_1000;
        bus.lsu_wen       = 1'b1;
        bus.lsu_wdata     = 32'hDEAD_BEEF;
        bus.lsu_wmask     = 8'h0F;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0004;
        sb.push_back('{OWN_LSU, 32'h0000_0000});
        sb.push_back('{OWN_IFU, 32'h0010_0073});
        #1;
        check("tie_lsu_ready", {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b01);
        tick();
        bus.lsu_req_valid = 1'b0;
        bus.lsu_wen       = 1'b0;
        serve(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 8'h0F, 0, 32'h0);
        check("after_lsu_ifu_ready", {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b10);
        tick();
        bus.ifu_req_valid = 1'b0;
        serve(32'h8000_0004, 1'b0, 32'h0, 8'h00, 0, 32'h0010_0073);

        // Fresh reset, then four ties.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.ifu_req_valid = 1'b1;
            bus.ifu_addr      = 32'h8000_0100 + 32'(i * 4);
            bus.lsu_req_valid = 1'b1;
            bus.lsu_addr      = 32'h8000_2000 + 32'(i * 4);
            bus.lsu_wen       = 1'b0;
            bus.lsu_wdata     = 32'h5555_0000 + 32'(i);
            bus.lsu_wmask     = 8'hFF;
            sb.push_back('{tie_win[i], 32'h0000_1000 + 32'(i)});
            #1;
            check("tie_grant", {bus.ifu_req_ready, bus.lsu_req_ready},
                  (tie_win[i] == OWN_IFU) ? 2'b10 : 2'b01);
            tick();
            bus.ifu_req_valid = 1'b0;
            bus.lsu_req_valid = 1'b0;
            if (tie_win[i] == OWN_IFU)
                serve(32'h8000_0100 + 32'(i * 4), 1'b0, 32'h0, 8'h00, 0, 32'h0000_1000 + 32'(i));
            else
                serve(32'h8000_2000 + 32'(i * 4), 1'b0, 32'h5555_0000 + 32'(i), 8'hFF, 0,
                      32'h0000_1000 + 32'(i));
        end

        // Backpressure: three cycles of mem_req_ready low on a store.
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 32'h8000_3000;
        bus.lsu_wen       = 1'b1;
        bus.lsu_wdata     = 32'h1234_5678;
        bus.lsu_wmask     = 8'hF0;
        sb.push_back('{OWN_LSU, 32'hCAFE_0001});
        tick();
        bus.lsu_req_valid = 1'b0;
        bus.lsu_addr      = 32'h0;
        bus.lsu_wdata     = 32'h0;
        bus.lsu_wmask     = 8'h00;
        serve(32'h8000_3000, 1'b1, 32'h1234_5678, 8'hF0, 3, 32'hCAFE_0001);

        // Spurious response in IDLE, then in REQ.
        bus.mem_resp_valid = 1'b1;
        #1;
        check("spur_idle_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 2'b00);
        tick();
        bus.mem_resp_valid = 1'b0;
        #1;
        check("spur_idle_state", busy, 1'b0);
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0040;
        sb.push_back('{OWN_IFU, 32'h0000_0013});
        tick();
        bus.ifu_req_valid  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        #1;
        check("spur_req_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 2'b00);
        tick();
        bus.mem_resp_valid = 1'b0;
        serve(32'h8000_0040, 1'b0, 32'h0, 8'h00, 0, 32'h0000_0013);

        // Reset while an LSU load sits in WAIT: dropped without a response.
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 32'h8000_4000;
        bus.lsu_wen       = 1'b0;
        tick();
        bus.lsu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready  = 1'b0;
        #1;
        check("rstw_in_wait", busy, 1'b1);
        rst_n              = 1'b0;
        bus.mem_resp_valid = 1'b1;
        #1;
        check("rstw_held_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 2'b00);
        check("rstw_held_busy", busy, 1'b0);
        tick();
        rst_n              = 1'b1;
        bus.mem_resp_valid = 1'b0;
        #1;
        check("rstw_busy", busy, 1'b0);
        check("rstw_outputs", {bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid,
                               bus.ifu_resp_valid, bus.lsu_resp_valid}, 5'b0);
        check("rstw_fields", {bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask}, '0);
        tick();
        bus.mem_resp_valid = 1'b1;
        #1;
        check("rstw_late_resp", bus.lsu_resp_valid, 1'b0);
        tick();
        bus.mem_resp_valid = 1'b0;
        tick();

        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
